// File: rtl/vx_wb_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_wb_sink_pkg
// Description : Shared widths, beat layout and the per-warp packet-tracking
//               state for the writeback sink.
//               ISSUE_WIS_W   - warp-in-slot index width
//               RRS_WIS_W     - rename/release slot id width
//               wb_sink_beat_t - buffered beat (uuid and PC are not kept)
// Revision    : 1.0 - initial release
// ============================================================================
package vx_wb_sink_pkg;

    localparam int NUM_THREADS   = 2;
    localparam int XLEN          = 32;
    localparam int NR_BITS       = 5;
    localparam int ISSUE_WIS_W   = 2;
    localparam int RRS_WIS_W     = 2;
    localparam int UUID_W        = 44;
    localparam int PC_W          = 32;
    localparam int PERF_CTR_BITS = 16;
    localparam int NUM_WIS       = 1 << ISSUE_WIS_W;

    typedef enum logic [0:0] {
        WB_SINK_IDLE   = 1'b0,
        WB_SINK_IN_PKT = 1'b1
    } wb_sink_state_e;

    typedef struct packed {
        logic [ISSUE_WIS_W-1:0]      wis;
        logic [NUM_THREADS-1:0]      tmask;
        logic [NR_BITS-1:0]          rd;
        logic [NUM_THREADS*XLEN-1:0] data;
        logic                        sop;
        logic                        eop;
        logic [RRS_WIS_W-1:0]        rrs_id;
    } wb_sink_beat_t;

    // Packet sequencing: a violation always returns the warp to IDLE so the
    // next well-formed packet starts cleanly.
    function automatic wb_sink_state_e wb_sink_next_state(
        input  wb_sink_state_e cur,
        input  logic           sop,
        input  logic           eop,
        output logic           proto_err
    );
        wb_sink_state_e nxt;
        proto_err = 1'b0;
        nxt       = cur;
        case (cur)
            WB_SINK_IDLE: begin
                if (!sop) begin
                    proto_err = 1'b1;
                    nxt       = WB_SINK_IDLE;
                end else if (!eop) begin
                    nxt = WB_SINK_IN_PKT;
                end
            end
            WB_SINK_IN_PKT: begin
                if (sop) begin
                    proto_err = 1'b1;
                    nxt       = WB_SINK_IDLE;
                end else if (eop) begin
                    nxt = WB_SINK_IDLE;
                end
            end
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vx_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_writeback_if
// Description : Writeback beat bundle. No ready signal: the slave must take
//               every valid beat.
// Revision    : 1.0 - initial release
// ============================================================================
interface vx_writeback_if;
    import vx_wb_sink_pkg::*;

    logic                              valid;
    logic [UUID_W-1:0]                 uuid;
    logic [ISSUE_WIS_W-1:0]            wis;
    logic [NUM_THREADS-1:0]            tmask;
    logic [PC_W-1:0]                   PC;
    logic [NR_BITS-1:0]                rd;
    logic [NUM_THREADS-1:0][XLEN-1:0]  data;
    logic                              sop;
    logic                              eop;
    logic [RRS_WIS_W-1:0]              rrs_id;

    modport master (output valid, uuid, wis, tmask, PC, rd, data, sop, eop, rrs_id);
    modport slave  (input  valid, uuid, wis, tmask, PC, rd, data, sop, eop, rrs_id);
endinterface

`default_nettype wire

// File: rtl/vx_wb_sink_fifo_queue.sv
`default_nettype none
// ============================================================================
// Module      : vx_wb_sink_fifo_queue
// Description : Circular beat buffer with combinational head read.
//               Ports: clk, rst (sync, active-high), i_push/i_data,
//               i_pop/o_data, o_empty, o_full.
//               Push and pop may occur in the same cycle, including when full.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_wb_sink_fifo_queue #(
    parameter int DATAW = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [DATAW-1:0] i_data,
    input  logic             i_pop,
    output logic [DATAW-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int ADDRW = $clog2(DEPTH);

    logic [DATAW-1:0] r_mem [DEPTH];
    logic [ADDRW-1:0] r_wr_ptr;
    logic [ADDRW-1:0] r_rd_ptr;
    logic [ADDRW:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (ADDRW+1)'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/vx_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : vx_wb_sink
// Description : Buffers writeback beats and forwards them to the register
//               file; x0 writes are drained silently. Releases the scoreboard
//               entry when an eop beat drains and tracks sop/eop sequencing
//               per warp.
//   clk, reset (sync, active-low)
//   writeback_if                  - inbound beats, no backpressure
//   rf_wr_valid/ready, rf_wr_*    - register-file write port
//   release_valid, release_*      - one-cycle scoreboard release
//   err_overflow, err_proto       - sticky error flags
//   perf_beats, perf_stalls       - present only with WB_SINK_PERF_EN
// Revision    : 1.0 - initial release
// ============================================================================
module vx_wb_sink
    import vx_wb_sink_pkg::*;
#(
    parameter int    DEPTH       = 4,
    parameter string INSTANCE_ID = ""
) (
    input  logic                             clk,
    input  logic                             reset,
    vx_writeback_if.slave                    writeback_if,
    output logic                             rf_wr_valid,
    input  logic                             rf_wr_ready,
    output logic [ISSUE_WIS_W-1:0]           rf_wr_wis,
    output logic [NR_BITS-1:0]               rf_wr_rd,
    output logic [NUM_THREADS-1:0]           rf_wr_tmask,
    output logic [NUM_THREADS-1:0][XLEN-1:0] rf_wr_data,
    output logic                             release_valid,
    output logic [ISSUE_WIS_W-1:0]           release_wis,
    output logic [NR_BITS-1:0]               release_rd,
    output logic [RRS_WIS_W-1:0]             release_rrs_id,
    output logic                             err_overflow,
    output logic                             err_proto
`ifdef WB_SINK_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]         perf_beats,
    output logic [PERF_CTR_BITS-1:0]         perf_stalls
`endif
);

    wb_sink_beat_t  w_in_beat;
    wb_sink_beat_t  w_head;
    logic           w_rst;
    logic           w_empty;
    logic           w_full;
    logic           w_in_valid;
    logic           w_head_valid;
    logic           w_is_x0;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    logic           w_proto_err;
    logic           w_unused;
    wb_sink_state_e r_state      [NUM_WIS];
    wb_sink_state_e w_state_next [NUM_WIS];
    logic           r_err_overflow;
    logic           r_err_proto;

    assign w_unused = &{1'b0, writeback_if.uuid, writeback_if.PC};

    assign w_in_beat = '{
        wis:    writeback_if.wis,
        tmask:  writeback_if.tmask,
        rd:     writeback_if.rd,
        data:   writeback_if.data,
        sop:    writeback_if.sop,
        eop:    writeback_if.eop,
        rrs_id: writeback_if.rrs_id
    };

    assign w_rst = !reset;

    vx_wb_sink_fifo_queue #(
        .DATAW ($bits(wb_sink_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (w_rst),
        .i_push  (w_push),
        .i_data  (w_in_beat),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Gating with reset keeps the head invisible while reset is held, so no
    // write or release escapes in the cycle that discards the buffer.
    assign w_head_valid = !w_empty && reset;
    assign w_in_valid   = writeback_if.valid && reset;
    assign w_is_x0      = (w_head.rd == '0);
    assign w_pop        = w_head_valid && (w_is_x0 || rf_wr_ready);
    // A pop in the same cycle frees the slot the incoming beat needs.
    assign w_push       = w_in_valid && (!w_full || w_pop);
    assign w_drop       = w_in_valid && w_full && !w_pop;

    assign rf_wr_valid    = w_head_valid && !w_is_x0;
    assign rf_wr_wis      = rf_wr_valid ? w_head.wis   : '0;
    assign rf_wr_rd       = rf_wr_valid ? w_head.rd    : '0;
    assign rf_wr_tmask    = rf_wr_valid ? w_head.tmask : '0;
    assign rf_wr_data     = rf_wr_valid ? w_head.data  : '0;

    assign release_valid  = w_pop && w_head.eop;
    assign release_wis    = release_valid ? w_head.wis    : '0;
    assign release_rd     = release_valid ? w_head.rd     : '0;
    assign release_rrs_id = release_valid ? w_head.rrs_id : '0;

    // Only the warp of an accepted beat advances; dropped beats leave it alone.
    always_comb begin
        w_state_next = r_state;
        w_proto_err  = 1'b0;
        if (w_push) begin
            w_state_next[w_in_beat.wis] = wb_sink_next_state(
                r_state[w_in_beat.wis], w_in_beat.sop, w_in_beat.eop, w_proto_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WIS; i++) begin
                r_state[i] <= WB_SINK_IDLE;
            end
            r_err_overflow <= 1'b0;
            r_err_proto    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_err_overflow <= r_err_overflow | w_drop;
            r_err_proto    <= r_err_proto | w_proto_err;
        end
    end

    assign err_overflow = r_err_overflow;
    assign err_proto    = r_err_proto;

`ifdef WB_SINK_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf_beats;
    logic [PERF_CTR_BITS-1:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_beats  <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_push)                      r_perf_beats  <= r_perf_beats + 1'b1;
            if (rf_wr_valid && !rf_wr_ready) r_perf_stalls <= r_perf_stalls + 1'b1;
        end
    end

    assign perf_beats  = r_perf_beats;
    assign perf_stalls = r_perf_stalls;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert ((DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))
            else $error("%s: DEPTH must be a power of two >= 2", INSTANCE_ID);
        if (reset) begin
            assert (!(w_pop && w_empty))
                else $error("%s: pop from empty beat buffer", INSTANCE_ID);
        end
    end
`endif

endmodule

`default_nettype wire
